// File: rtl/inst_splitter_if.sv
// inst_splitter_if: fetch, redirect and multi-slot output signals of the
// 6502 instruction splitter. "slave" is the splitter's view, "master" is the
// view of the fetch unit / downstream FIFO side.
interface inst_splitter_if #(
  parameter int FETCH_BYTES = 4,
  parameter int PUSH_WIDTH  = 4
);
  localparam int CTW = $clog2(PUSH_WIDTH) + 1;

  logic                     redirect;
  logic [15:0]              redirect_pc;
  logic [8*FETCH_BYTES-1:0] fetch_data;
  logic                     fetch_valid;
  logic                     fetch_ready;
  logic [40*PUSH_WIDTH-1:0] dout;
  logic [CTW-1:0]           dout_valid_ct;
  logic [CTW-1:0]           dout_ready_ct;

  modport master (
    output redirect, redirect_pc, fetch_data, fetch_valid, dout_ready_ct,
    input  fetch_ready, dout, dout_valid_ct
  );

  modport slave (
    input  redirect, redirect_pc, fetch_data, fetch_valid, dout_ready_ct,
    output fetch_ready, dout, dout_valid_ct
  );
endinterface

// File: rtl/inst_splitter.sv
// inst_splitter: accepts fetch beats of raw 6502 code bytes into a small
// shifting byte buffer, splits the buffer head into up to PUSH_WIDTH complete
// instructions per cycle (opcode, operands, PC) and retires whatever the
// downstream FIFO accepts.
// Optional build macro INST_SPLITTER_CF_STOP_EN: when defined, a cycle's
// parse ends at the first control-flow opcode.
module inst_splitter #(
  parameter int FETCH_BYTES = 4,
  parameter int PUSH_WIDTH  = 4,
  parameter int BUF_BYTES   = 2 * FETCH_BYTES
) (
  input logic            clk,
  input logic            rst,
  inst_splitter_if.slave bus
);
  localparam int CTW = $clog2(PUSH_WIDTH) + 1;
  localparam int CW  = $clog2(BUF_BYTES + 1);

`ifdef INST_SPLITTER_CF_STOP_EN
  localparam bit CF_STOP = 1'b1;
`else
  localparam bit CF_STOP = 1'b0;
`endif

  logic [7:0]     byte_q [BUF_BYTES];
  logic [CW-1:0]  count_q;
  logic [15:0]    pc_q;

  logic [7:0]     pad [BUF_BYTES+2];
  logic [7:0]     slot_op [PUSH_WIDTH];
  logic [7:0]     slot_o1 [PUSH_WIDTH];
  logic [7:0]     slot_o2 [PUSH_WIDTH];
  logic [1:0]     slot_len [PUSH_WIDTH];
  logic [15:0]    slot_pc [PUSH_WIDTH];
  logic           slot_ok [PUSH_WIDTH];
  logic [CTW-1:0] parsed_ct;
  logic [CTW-1:0] valid_ct;
  logic [CTW-1:0] take_ct;
  logic [CW-1:0]  cons_bytes;
  logic [CW-1:0]  count_d;
  logic [7:0]     byte_d [BUF_BYTES];
  logic           accept;

  // NMOS 6502 documented instruction lengths; undocumented opcodes count as 1.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    case (op)
      // immediate
      8'h09, 8'h29, 8'h49, 8'h69, 8'hA0, 8'hA2, 8'hA9, 8'hC0, 8'hC9, 8'hE0,
      8'hE9,
      // zero page
      8'h05, 8'h06, 8'h24, 8'h25, 8'h26, 8'h45, 8'h46, 8'h65, 8'h66, 8'h84,
      8'h85, 8'h86, 8'hA4, 8'hA5, 8'hA6, 8'hC4, 8'hC5, 8'hC6, 8'hE4, 8'hE5,
      8'hE6,
      // zero page indexed
      8'h15, 8'h16, 8'h35, 8'h36, 8'h55, 8'h56, 8'h75, 8'h76, 8'h94, 8'h95,
      8'hB4, 8'hB5, 8'hD5, 8'hD6, 8'hF5, 8'hF6, 8'h96, 8'hB6,
      // (zp,X) and (zp),Y
      8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1,
      8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1,
      // relative branches
      8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
        op_len = 2'd2;
      // absolute, including JMP and JSR
      8'h0D, 8'h0E, 8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h4C, 8'h4D, 8'h4E, 8'h6D,
      8'h6E, 8'h8C, 8'h8D, 8'h8E, 8'hAC, 8'hAD, 8'hAE, 8'hCC, 8'hCD, 8'hCE,
      8'hEC, 8'hED, 8'hEE,
      // absolute,X
      8'h1D, 8'h1E, 8'h3D, 8'h3E, 8'h5D, 8'h5E, 8'h7D, 8'h7E, 8'h9D, 8'hBC,
      8'hBD, 8'hDD, 8'hDE, 8'hFD, 8'hFE,
      // absolute,Y
      8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hBE, 8'hD9, 8'hF9,
      // JMP indirect
      8'h6C:
        op_len = 2'd3;
      default:
        op_len = 2'd1;
    endcase
  endfunction

  // Opcodes that can change the flow of control: jumps, calls, returns, BRK
  // and the eight conditional branches.
  function automatic logic is_cf(input logic [7:0] op);
    case (op)
      8'h4C, 8'h6C, 8'h20, 8'h60, 8'h40, 8'h00,
      8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
        is_cf = 1'b1;
      default:
        is_cf = 1'b0;
    endcase
  endfunction

  // Zero-padded copy of the buffer so operand lookups near the tail stay in range.
  always_comb begin
    for (int p = 0; p < BUF_BYTES; p++) pad[p] = byte_q[p];
    pad[BUF_BYTES]     = '0;
    pad[BUF_BYTES + 1] = '0;
  end

  // Walk the buffer from byte 0, emitting complete instructions in order.
  always_comb begin
    int         off;
    logic       stop;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [1:0] len;
    off       = 0;
    stop      = 1'b0;
    parsed_ct = '0;
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      slot_op[k]  = '0;
      slot_o1[k]  = '0;
      slot_o2[k]  = '0;
      slot_len[k] = '0;
      slot_pc[k]  = '0;
      slot_ok[k]  = 1'b0;
      b0 = '0;
      b1 = '0;
      b2 = '0;
      for (int p = 0; p < BUF_BYTES; p++) begin
        if (off == p) begin
          b0 = pad[p];
          b1 = pad[p + 1];
          b2 = pad[p + 2];
        end
      end
      len = op_len(b0);
      // A partial instruction at the tail ends the parse until it completes.
      if (!stop && (off + int'(len) <= int'(count_q))) begin
        slot_ok[k]  = 1'b1;
        slot_op[k]  = b0;
        slot_o1[k]  = (len >= 2'd2) ? b1 : 8'h00;
        slot_o2[k]  = (len == 2'd3) ? b2 : 8'h00;
        slot_len[k] = len;
        slot_pc[k]  = pc_q + 16'(off);
        parsed_ct   = parsed_ct + CTW'(1);
        off         = off + int'(len);
        if (CF_STOP && is_cf(b0)) stop = 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
  end

  // Output count, slots actually taken downstream, and bytes they retire.
  always_comb begin
    valid_ct   = bus.redirect ? '0 : parsed_ct;
    take_ct    = (bus.dout_ready_ct < valid_ct) ? bus.dout_ready_ct : valid_ct;
    cons_bytes = '0;
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      if (k < int'(take_ct)) cons_bytes = cons_bytes + CW'(slot_len[k]);
    end
  end

  // Room check uses pre-consumption occupancy so it never depends on downstream ready.
  always_comb begin
    bus.fetch_ready = !bus.redirect && (int'(count_q) <= BUF_BYTES - FETCH_BYTES);
    accept          = bus.fetch_valid && bus.fetch_ready;
  end

  // Shift out consumed bytes and append an accepted beat right after the survivors.
  always_comb begin
    int keep;
    keep = int'(count_q) - int'(cons_bytes);
    for (int i = 0; i < BUF_BYTES; i++) begin
      byte_d[i] = '0;
      for (int j = 0; j < BUF_BYTES; j++) begin
        if ((j == i + int'(cons_bytes)) && (j < int'(count_q))) byte_d[i] = byte_q[j];
      end
      for (int f = 0; f < FETCH_BYTES; f++) begin
        if (accept && (i == keep + f)) byte_d[i] = bus.fetch_data[8*f +: 8];
      end
    end
    count_d = count_q - cons_bytes + (accept ? CW'(FETCH_BYTES) : '0);
  end

  // Pack valid slots; everything past the last valid slot reads as zero.
  always_comb begin
    bus.dout = '0;
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      if (slot_ok[k] && !bus.redirect) begin
        bus.dout[40*k +: 40] = {slot_pc[k], slot_o2[k], slot_o1[k], slot_op[k]};
      end
    end
    bus.dout_valid_ct = valid_ct;
  end

  // Buffer, occupancy and PC; reset beats redirect, redirect beats consume/append.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pc_q    <= '0;
      for (int i = 0; i < BUF_BYTES; i++) byte_q[i] <= '0;
    end else if (bus.redirect) begin
      count_q <= '0;
      pc_q    <= bus.redirect_pc;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_q + 16'(cons_bytes);
      for (int i = 0; i < BUF_BYTES; i++) byte_q[i] <= byte_d[i];
    end
  end
endmodule

// File: doc/inst_splitter.md
INST_SPLITTER -- requirements
Module: inst_splitter

Interface
REQ-001 SHALL have parameter FETCH_BYTES, default 4: bytes accepted per fetch beat.
REQ-002 SHALL have parameter PUSH_WIDTH, default 4: max instructions emitted per cycle.
REQ-003 SHALL have parameter BUF_BYTES, default 2*FETCH_BYTES: byte buffer capacity; must be >= FETCH_BYTES+2.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 redirect  input  1  flush buffer and restart at redirect_pc.
REQ-007 redirect_pc  input  16  new PC on redirect.
REQ-008 fetch_data  input  8*FETCH_BYTES  sequential bytes; byte 0 in [7:0] is the lowest address.
REQ-009 fetch_valid  input  1  fetch_data valid.
REQ-010 fetch_ready  output  1  beat accepted when fetch_valid & fetch_ready.
REQ-011 dout  output  40*PUSH_WIDTH  packed instructions, slot k at [40k+:40]; per slot [7:0] opcode, [15:8] operand1, [23:16] operand2, [39:24] instruction PC.
REQ-012 dout_valid_ct  output  clog2(PUSH_WIDTH)+1  number of valid slots, LSB slot first.
REQ-013 dout_ready_ct  input  clog2(PUSH_WIDTH)+1  slots downstream accepts this cycle; driven by the downstream multi-push FIFO.

Function
REQ-014 Instruction length SHALL follow the NMOS 6502 documented opcode table (1, 2 or 3 bytes); undocumented opcodes SHALL be length 1.
REQ-015 Parse SHALL start at buffer byte 0; slot k SHALL be emitted only if slots 0..k-1 are emitted and all bytes of instruction k are in the buffer.
REQ-016 dout_valid_ct SHALL equal min(complete instructions parsed, PUSH_WIDTH), computed combinationally from registered buffer state only; no fetch_data bypass, minimum latency 1 cycle.
REQ-017 Consumed count SHALL be min(dout_valid_ct, dout_ready_ct); consumed bytes SHALL be removed at the clock edge and remaining bytes shifted to byte 0.
REQ-018 Operand bytes beyond instruction length SHALL be driven 0; slots >= dout_valid_ct SHALL be driven 0.
REQ-019 Instruction PC SHALL start at the reset/redirect PC and advance by each consumed instruction's length, wrapping modulo 2^16.
REQ-020 fetch_ready SHALL be 1 iff free bytes, computed before this cycle's consumption, >= FETCH_BYTES and redirect is 0.
REQ-021 An accepted beat SHALL be appended after the bytes remaining post-consumption in the same edge.
REQ-022 On redirect the buffer SHALL be emptied, PC loaded with redirect_pc, dout_valid_ct forced to 0 and any fetch beat dropped that cycle; redirect takes priority over consume and append.
REQ-023 A partial instruction at the buffer tail SHALL be held, not emitted, until its remaining bytes arrive.

Reset
REQ-024 rst SHALL have priority over redirect and all other inputs.
REQ-025 After reset: buffer empty, PC = 16'h0000, dout_valid_ct = 0, dout = 0, fetch_ready = 1.

Configuration
REQ-026 Macro INST_SPLITTER_CF_STOP_EN defined: parsing SHALL stop after the first control-flow opcode (JMP abs/ind, JSR, RTS, RTI, BRK, all 8 branches) in a cycle; that instruction SHALL be the last valid slot.
REQ-027 Macro undefined: control-flow opcodes SHALL be parsed like any other opcode.

Verification
REQ-028 Reset: assert rst 2 cycles -> dout_valid_ct=0, fetch_ready=1; the first emitted PC is 0000.
REQ-029 Split: beat A9 05 EA 8D, ready_ct=4 -> next cycle valid_ct=2 (A9/05 PC 0000, EA PC 0002); beat 00 02 EA EA -> valid_ct=3 (8D/00/02 PC 0003, EA PC 0006, EA PC 0007).
REQ-030 Backpressure: buffer holds EA EA EA EA, ready_ct=1 -> valid_ct=4, one consumed per cycle, PCs 0000..0003 over 4 cycles, fetch_ready=0 while free < FETCH_BYTES.
REQ-031 Redirect: buffer non-empty, redirect=1 with redirect_pc=C000 -> same cycle valid_ct=0, fetch_ready=0; next beat EA.. emits PC C000.
REQ-032 CF stop: beat 4C 00 10 EA -> with INST_SPLITTER_CF_STOP_EN valid_ct=1 then EA next cycle at PC 0003; without it valid_ct=2.
REQ-033 Wrap: redirect_pc=FFFF, beat EA EA EA EA -> PCs FFFF, 0000, 0001, 0002.
